// File: rtl/sbc_pkg.sv
// Shared types and default constants for the SBC clock/reset generator.
// Imported by the top and its sub-module.
package sbc_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } rst_state_e;

  localparam int PHI2_DIV_DEF = 25;
  localparam int NCO_INC_DEF  = 618475;
  localparam int RES_HOLD_DEF = 16;

endpackage

// File: rtl/sbc_clk_reset_gen_if.sv
// Board-side signals of the clock/reset generator.
// master = generator, slave = board/consumer side.
interface sbc_clk_reset_gen_if;

  logic pll_locked;
  logic btn_n;
  logic phi2;
  logic phi2_rise;
  logic phi2_fall;
  logic uart_clk;
  logic res_n;

  modport master (
    input  pll_locked,
    input  btn_n,
    output phi2,
    output phi2_rise,
    output phi2_fall,
    output uart_clk,
    output res_n
  );

  modport slave (
    output pll_locked,
    output btn_n,
    input  phi2,
    input  phi2_rise,
    input  phi2_fall,
    input  uart_clk,
    input  res_n
  );

endinterface

// File: rtl/sbc_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// Output starts at 0 (pressed) out of reset.
module sbc_debounce
  import sbc_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic res_i,
  input  logic din_i,
  output logic dout_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          s;

  assign s = sync_q[1];

  // Any cycle where the input agrees with the output restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], din_i};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o = deb_q;

endmodule

// File: rtl/sbc_clk_reset_gen.sv
// phi2 divider, UART NCO and sequenced system reset for the SBC.
// res_n releases aligned to a phi2 falling edge.
module sbc_clk_reset_gen
  import sbc_pkg::*;
#(
  parameter int PHI2_DIV   = PHI2_DIV_DEF,
  parameter int NCO_W      = 24,
  parameter int NCO_INC    = NCO_INC_DEF,
  parameter int RES_HOLD   = RES_HOLD_DEF,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                fst_clk,
  input  logic                res,
  sbc_clk_reset_gen_if.master bus
);

  localparam logic [7:0] DIV_LAST  = 8'(PHI2_DIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(RES_HOLD - 1);
  localparam logic [NCO_W-1:0] NCO_STEP = NCO_W'(NCO_INC);

  logic [7:0]       div_q;
  logic [7:0]       div_d;
  logic             phi2_q;
  logic             phi2_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;
  logic [NCO_W-1:0] acc_q;
  logic [NCO_W-1:0] acc_d;
  logic             wrap;
  logic             fall_evt;

  logic [1:0]       pll_sync_q;
  logic             btn_rel;
  logic             go_wait;

  rst_state_e       st_q;
  logic [7:0]       hold_q;
  logic             res_n_q;

  // fall_evt marks the edge on which phi2 is about to drop to 0.
  always_comb begin
    wrap     = (div_q == DIV_LAST);
    fall_evt = wrap & phi2_q;
    div_d    = wrap ? 8'd0 : div_q + 8'd1;
    phi2_d   = phi2_q ^ wrap;
    rise_d   = wrap & ~phi2_q;
    fall_d   = fall_evt;
    acc_d    = acc_q + NCO_STEP;
  end

  always_ff @(posedge fst_clk) begin
    if (res) begin
      div_q  <= '0;
      phi2_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      div_q  <= div_d;
      phi2_q <= phi2_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      acc_q  <= acc_d;
    end
  end

  always_ff @(posedge fst_clk) begin
    if (res) begin
      pll_sync_q <= '0;
    end else begin
      pll_sync_q <= {pll_sync_q[0], bus.pll_locked};
    end
  end

  sbc_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_deb (
    .clk_i (fst_clk),
    .res_i (res),
    .din_i (bus.btn_n),
    .dout_o(btn_rel)
  );

  assign go_wait = ~pll_sync_q[1] | ~btn_rel;

  // go_wait is tested first so it beats a coincident final strobe.
  always_ff @(posedge fst_clk) begin
    if (res) begin
      st_q    <= ST_WAIT;
      hold_q  <= '0;
      res_n_q <= 1'b0;
    end else begin
      unique case (st_q)
        ST_WAIT: begin
          hold_q  <= '0;
          res_n_q <= 1'b0;
          if (!go_wait) begin
            st_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (go_wait) begin
            st_q    <= ST_WAIT;
            hold_q  <= '0;
            res_n_q <= 1'b0;
          end else if (fall_evt) begin
            if (hold_q == HOLD_LAST) begin
              st_q    <= ST_RUN;
              hold_q  <= '0;
              res_n_q <= 1'b1;
            end else begin
              hold_q <= hold_q + 8'd1;
            end
          end
        end
        ST_RUN: begin
          if (go_wait) begin
            st_q    <= ST_WAIT;
            res_n_q <= 1'b0;
          end
        end
        default: begin
          st_q    <= ST_WAIT;
          hold_q  <= '0;
          res_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phi2      = phi2_q;
  assign bus.phi2_rise = rise_q;
  assign bus.phi2_fall = fall_q;
  assign bus.uart_clk  = acc_q[NCO_W-1];
  assign bus.res_n     = res_n_q;

endmodule

// File: tb/tb_sbc_clk_reset_gen.sv
// Directed bench for sbc_clk_reset_gen with small parameters.
// cyc counts edges since the last res release.
module tb_sbc_clk_reset_gen;

  localparam int NEVER = 1 << 30;

  logic clk = 1'b0;
  logic res;

  sbc_clk_reset_gen_if bus();

  always #5 clk = ~clk;

  sbc_clk_reset_gen #(
    .PHI2_DIV  (2),
    .NCO_W     (8),
    .NCO_INC   (64),
    .RES_HOLD  (4),
    .DEB_CYCLES(8)
  ) dut (
    .fst_clk(clk),
    .res    (res),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit track    = 1'b0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  // PHI2_DIV=2, NCO 64/256: phi2 and uart_clk are high
  // for cyc%4 in {2,3}; rise at 2, fall at 0.
  task automatic tick();
    int ph;
    @(posedge clk);
    #1;
    cyc++;
    if (track) begin
      ph = cyc % 4;
      chk("phi2", 32'(bus.phi2), 32'(ph >= 2));
      chk("rise", 32'(bus.phi2_rise), 32'(ph == 2));
      chk("fall", 32'(bus.phi2_fall), 32'(ph == 0));
      chk("uart", 32'(bus.uart_clk), 32'(ph >= 2));
    end
  endtask

  task automatic run_to(int tgt, int lo, int hi);
    while (cyc < tgt) begin
      tick();
      chk("res_n", 32'(bus.res_n),
          32'(cyc >= lo && cyc < hi));
    end
  endtask

  task automatic reset_chk(string tag);
    chk({tag, "_phi2"}, 32'(bus.phi2), 32'd0);
    chk({tag, "_rise"}, 32'(bus.phi2_rise), 32'd0);
    chk({tag, "_fall"}, 32'(bus.phi2_fall), 32'd0);
    chk({tag, "_uart"}, 32'(bus.uart_clk), 32'd0);
    chk({tag, "_res_n"}, 32'(bus.res_n), 32'd0);
  endtask

  initial begin
    res = 1'b1;
    bus.pll_locked = 1'b1;
    bus.btn_n = 1'b1;
    repeat (3) tick();
    reset_chk("por");

    res = 1'b0;
    cyc = 0;
    track = 1'b1;
    run_to(24, 24, NEVER);
    run_to(280, 24, NEVER);

    repeat (3) begin
      bus.btn_n = 1'b0;
      run_to(cyc + 3, 24, NEVER);
      bus.btn_n = 1'b1;
      run_to(cyc + 1, 24, NEVER);
    end
    bus.btn_n = 1'b0;
    run_to(302, 24, NEVER);
    bus.btn_n = 1'b1;
    run_to(328, 328, NEVER);

    run_to(330, 328, NEVER);
    bus.pll_locked = 1'b0;
    run_to(336, 0, 333);
    bus.pll_locked = 1'b1;
    run_to(360, 352, NEVER);

    bus.pll_locked = 1'b0;
    run_to(363, 0, 363);
    bus.pll_locked = 1'b1;
    run_to(373, NEVER, NEVER);
    res = 1'b1;
    track = 1'b0;
    tick();
    reset_chk("res_hold");
    res = 1'b0;
    cyc = 0;
    track = 1'b1;
    run_to(30, 24, NEVER);

    res = 1'b1;
    track = 1'b0;
    tick();
    reset_chk("res_run");
    res = 1'b0;
    cyc = 0;
    track = 1'b1;
    run_to(13, NEVER, NEVER);
    bus.btn_n = 1'b0;
    run_to(40, NEVER, NEVER);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
